// File: rtl/updown_seq_checker_if.sv
// Count-stream bus between a bouncing up/down count source and its checker.
// The master drives the sample stream and error clear; the slave returns lock/status.
interface updown_seq_checker_if #(
  parameter int CNT_W = 3,
  parameter int ERR_W = 8
);
  logic [CNT_W-1:0] cnt_in;
  logic             cnt_vld;
  logic             err_clr;
  logic             locked;
  logic             dir;
  logic [CNT_W-1:0] exp_val;
  logic             turn;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output cnt_in, cnt_vld, err_clr,
    input  locked, dir, exp_val, turn, err, err_cnt
  );

  modport slave (
    input  cnt_in, cnt_vld, err_clr,
    output locked, dir, exp_val, turn, err, err_cnt
  );
endinterface

// File: rtl/updown_seq_checker.sv
// Receive-side checker for a bouncing BOT..TOP..BOT count stream (step +/-1).
// Locks after LOCK_CNT consecutive expected steps, then flags turn points and
// sequence errors and keeps a saturating error count.
module updown_seq_checker #(
  parameter int CNT_W    = 3,
  parameter int BOT      = 1,
  parameter int TOP      = 6,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  updown_seq_checker_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  prev;
  logic [GOOD_W-1:0] good_cnt;

  logic [CNT_W-1:0]  s;
  logic [CNT_W-1:0]  exp_cur;
  logic              in_rng;
  logic              step_up;
  logic              step_dn;
  logic              edge_val;

  // Expected next value from a previous sample and direction, bouncing at the ends.
  function automatic logic [CNT_W-1:0] next_exp(input logic [CNT_W-1:0] p, input logic d);
    if (!d) begin
      return (p == CNT_W'(TOP)) ? CNT_W'(TOP - 1) : p + CNT_W'(1);
    end
    return (p == CNT_W'(BOT)) ? CNT_W'(BOT + 1) : p - CNT_W'(1);
  endfunction

  // Classify the incoming sample against the range and the previous accepted value.
  always_comb begin
    s        = bus.cnt_in;
    exp_cur  = next_exp(prev, bus.dir);
    in_rng   = (s >= CNT_W'(BOT)) && (s <= CNT_W'(TOP));
    step_up  = (s == prev + CNT_W'(1));
    step_dn  = (s == prev - CNT_W'(1));
    edge_val = (s == CNT_W'(TOP)) || (s == CNT_W'(BOT));
  end

  // Lock FSM with registered status outputs; every state change is gated by cnt_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEEK;
      prev        <= '0;
      good_cnt    <= '0;
      bus.locked  <= 1'b0;
      bus.dir     <= 1'b0;
      bus.exp_val <= '0;
      bus.turn    <= 1'b0;
      bus.err     <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.turn <= 1'b0;
      bus.err  <= 1'b0;
      if (bus.err_clr) bus.err_cnt <= '0;
      if (bus.cnt_vld) begin
        case (state)
          SEEK: begin
            if (in_rng) begin
              state       <= FIRST;
              prev        <= s;
              bus.exp_val <= next_exp(s, bus.dir);
            end
          end
          FIRST: begin
            if (!in_rng) begin
              state <= SEEK;
            end else if (step_up || step_dn) begin
              state       <= TRACK;
              good_cnt    <= GOOD_W'(1);
              prev        <= s;
              bus.dir     <= step_dn;
              bus.exp_val <= next_exp(s, step_dn);
            end else begin
              prev        <= s;
              bus.exp_val <= next_exp(s, bus.dir);
            end
          end
          TRACK: begin
            if (s == exp_cur) begin
              good_cnt    <= good_cnt + GOOD_W'(1);
              prev        <= s;
              bus.dir     <= step_dn;
              bus.exp_val <= next_exp(s, step_dn);
              if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                state      <= LOCK;
                bus.locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
              if (in_rng) begin
                state       <= FIRST;
                prev        <= s;
                bus.exp_val <= next_exp(s, bus.dir);
              end else begin
                state <= SEEK;
              end
            end
          end
          LOCK: begin
            if (s == exp_cur) begin
              prev        <= s;
              bus.dir     <= step_dn;
              bus.exp_val <= next_exp(s, step_dn);
              bus.turn    <= edge_val;
            end else begin
              bus.err    <= 1'b1;
              bus.locked <= 1'b0;
              good_cnt   <= '0;
              // err_clr already zeroed the count above and must win
              if (!bus.err_clr && (bus.err_cnt != '1)) bus.err_cnt <= bus.err_cnt + ERR_W'(1);
              if (in_rng) begin
                state       <= FIRST;
                prev        <= s;
                bus.exp_val <= next_exp(s, bus.dir);
              end else begin
                state <= SEEK;
              end
            end
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

endmodule
